fpu_mul_seq: RTL

Sequential IEEE-754 single-precision multiplier that sits directly downstream of `judge`. It latches operands `a`/`b` together with `judge`'s special-case `flag` and hidden bits `hidea`/`hideb`, and resolves special cases in a fast path. For finite non-zero operands it forms the 24×24 significand product with a radix-2 shift-add loop, then normalises, rounds to nearest-even and packs the result. The block is the FPU multiply lane that the adder lane is built alongside.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_round.sv | 49 ++++
 rtl/fpu_mul_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU lanes (multiplier, adder, judge).
//   - flag encodings produced by judge (priority NaN > inf > zero)
//   - exponent constants and the canonical NaN pattern
//   - state encoding of the sequential multiplier FSM
package fpu_pkg;

    localparam logic [1:0] FLAG_NORM = 2'b00;  // both operands finite non-zero
    localparam logic [1:0] FLAG_ZERO = 2'b01;  // at least one zero
    localparam logic [1:0] FLAG_INF  = 2'b10;  // at least one infinity
    localparam logic [1:0] FLAG_NAN  = 2'b11;  // at least one NaN

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] NAN_CANON_DEF = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fpu_round.sv
// fpu_round: combinational round-to-nearest-even, overflow check and pack.
//   s      : result sign
//   e      : signed exponent of the P[46] weight, already >= 1 after normalisation
//   p      : 48-bit normalised significand product (P[46] = integer bit)
//   result : packed float32
module fpu_round
    import fpu_pkg::*;
(
    input  logic               s,
    input  logic signed [9:0]  e,
    input  logic        [47:0] p,
    output logic        [31:0] result
);

    localparam logic signed [9:0] EXP_LIM = 10'(EXP_MAX);

    logic              guard;
    logic              sticky;
    logic              round_up;
    logic       [24:0] sig_sum;
    logic signed [9:0] e_out;

    always_comb begin
        guard    = p[22];
        sticky   = |p[21:0];
        round_up = guard & (sticky | p[23]);
        sig_sum  = {1'b0, p[46:23]} + {24'd0, round_up};

        // Carry out of the 24-bit significand bumps the exponent; a denormal
        // that rounds into the P[46] weight keeps e (which is 1) and so becomes
        // the smallest normal. Without the integer bit the field is zero.
        if (sig_sum[24]) begin
            e_out = e + 10'sd1;
        end else if (sig_sum[23]) begin
            e_out = e;
        end else begin
            e_out = '0;
        end

        if (e_out >= EXP_LIM) begin
            result = {s, 8'hFF, 23'h0};
        end else if (sig_sum[24]) begin
            result = {s, e_out[7:0], sig_sum[23:1]};
        end else begin
            result = {s, e_out[7:0], sig_sum[22:0]};
        end
    end

endmodule

// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: sequential float32 multiplier fed by judge.
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   in_valid/ready  : operand handshake; a, b, flag, hidea, hideb sampled on accept
//   result          : packed product, stable while out_valid is high
//   out_valid/ready : result handshake
//   dbg_state       : current FSM state (fpu_pkg::state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// stays high with result unchanged until out_ready is seen. No new operands
// are accepted in the same cycle as the result handshake.
module fpu_mul_seq
    import fpu_pkg::*;
#(
    parameter logic [31:0] NAN_CANON = NAN_CANON_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  flag,
    input  logic        hidea,
    input  logic        hideb,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  dbg_state
);

    localparam logic signed [9:0] BIAS_E = 10'(BIAS);

    state_t             state, state_nx;
    logic               s_q;
    logic signed [9:0]  e_q;
    logic        [47:0] p_q;
    logic        [47:0] mcand_q;
    logic        [23:0] mplier_q;
    logic        [4:0]  cnt_q;
    logic        [31:0] result_q;

    logic               s_in;
    logic        [7:0]  ea_eff, eb_eff;
    logic        [31:0] special_res;
    logic               norm_rshift, norm_lshift;
    logic        [31:0] round_res;

    // Accept-cycle decode: sign, effective exponents and special results.
    always_comb begin
        s_in   = a[31] ^ b[31];
        ea_eff = hidea ? a[30:23] : 8'd1;
        eb_eff = hideb ? b[30:23] : 8'd1;
        case (flag)
            FLAG_NAN: special_res = NAN_CANON;
            FLAG_INF: special_res = ((a[30:0] == 31'd0) || (b[30:0] == 31'd0)) ?
                                    NAN_CANON : {s_in, 8'hFF, 23'h0};
            default:  special_res = {s_in, 31'h0};
        endcase
    end

    // Normalisation decisions: overflow bit or too-small exponent shift right
    // (with sticky), otherwise pull the integer bit up while the exponent allows.
    always_comb begin
        norm_rshift = p_q[47] || (e_q < 10'sd1);
        norm_lshift = !norm_rshift && !p_q[46] && (e_q > 10'sd1);
    end

    fpu_round u_round (
        .s      (s_q),
        .e      (e_q),
        .p      (p_q),
        .result (round_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (flag == FLAG_NORM) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (cnt_q == 5'd23) begin
                    state_nx = ST_NORM;
                end
            end
            ST_NORM: begin
                if (!norm_rshift && !norm_lshift) begin
                    state_nx = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q      <= 1'b0;
            e_q      <= '0;
            p_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        s_q      <= s_in;
                        e_q      <= $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - BIAS_E;
                        mcand_q  <= {24'd0, hidea, a[22:0]};
                        mplier_q <= {hideb, b[22:0]};
                        p_q      <= '0;
                        cnt_q    <= '0;
                        if (flag != FLAG_NORM) begin
                            result_q <= special_res;
                        end
                    end
                end
                ST_MUL: begin
                    // Radix-2, multiplier LSB first: multiplicand walks left.
                    if (mplier_q[0]) begin
                        p_q <= p_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                end
                ST_NORM: begin
                    if (norm_rshift) begin
                        p_q <= {1'b0, p_q[47:2], p_q[1] | p_q[0]};
                        e_q <= e_q + 10'sd1;
                    end else if (norm_lshift) begin
                        p_q <= p_q << 1;
                        e_q <= e_q - 10'sd1;
                    end
                end
                ST_ROUND: begin
                    result_q <= round_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = result_q;
    assign dbg_state = state;

endmodule
